down_counter_10bit: RTL

- Loadable 10-bit countdown timer. It is the decrementing counterpart of the team's up-counting rollover counter.
- Counts enabled cycles down from a loaded value and pulses a terminal flag on reaching its end.
- Supports one-shot and periodic (auto-reload) modes.
- Used by protocol blocks for timeouts, bit-period timing and inter-frame gaps.

---
 rtl/down_counter_10bit.sv | 99 +++++++++
 1 files changed

// File: rtl/down_counter_10bit.sv
// Loadable countdown timer with one-shot and periodic (auto-reload) modes.
// A load starts the count from load_val; each enabled cycle in RUN decrements
// it, and reaching the end of the count produces a one-cycle expire pulse.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | not counting; count_out holds its last value
// RUN   | counting down on enabled cycles; busy=1
// DONE  | one-shot count completed; count_out=0; otherwise like IDLE
`timescale 1ns/1ps

module down_counter_10bit #(
    parameter int NUM_CNT_BITS = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    auto_reload,
    input  logic                    count_enable,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    expire_flag,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

    state_t                  state_q,  state_d;
    logic [NUM_CNT_BITS-1:0] count_q,  count_d;
    logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
    logic                    mode_q,   mode_d;
    logic                    expire_q, expire_d;

    // State, count, reload value, mode and expire pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            mode_q   <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            expire_q <= expire_d;
        end
    end

    // Next-state logic; priority is clear, then load, then an enabled decrement.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        expire_d = 1'b0;

        if (clear) begin
            // reload value and mode survive a clear on purpose
            state_d = IDLE;
            count_d = CNT_ZERO;
        end else if (load) begin
            reload_d = load_val;
            mode_d   = auto_reload;
            count_d  = load_val;
            // a zero load has nothing to count, so it never enters RUN
            state_d  = (load_val != CNT_ZERO) ? RUN : IDLE;
        end else if ((state_q == RUN) && count_enable) begin
            if (count_q > CNT_ONE) begin
                count_d = count_q - CNT_ONE;
            end else if (count_q == CNT_ONE) begin
                expire_d = 1'b1;
                if (mode_q) begin
                    count_d = reload_q;
                end else begin
                    count_d = CNT_ZERO;
                    state_d = DONE;
                end
            end else begin
                // zero in RUN is unreachable; park safely instead of wrapping
                state_d = IDLE;
            end
        end
    end

    assign count_out   = count_q;
    assign expire_flag = expire_q;
    assign busy        = (state_q == RUN);

endmodule
